// File: rtl/memory_sequencer.sv
// memory_sequencer: start/done-controlled clear, fill and read sequencing for BlockMemoryStorage.
// One timer serves the clear length and all wait timeouts; it restarts on every state change.
module memory_sequencer #(
   parameter int ADDRESSBITS  = 16,
   parameter int COUNTBITS    = 16,
   parameter int CLEAR_CYCLES = 1,
   parameter int TIMEOUT      = 1024
) (
   input  logic                   clock,
   input  logic                   resetN,
   input  logic                   start,
   input  logic                   abort,
   input  logic [COUNTBITS-1:0]   numWrites,
   input  logic                   addrValid,
   input  logic [ADDRESSBITS-1:0] addrData,
   output logic                   addrAccept,
   output logic                   clearMemory,
   output logic                   newAddress,
   output logic [ADDRESSBITS-1:0] address,
   output logic                   readMemory,
   input  logic                   storageReady,
   input  logic                   readReady,
   output logic                   busy,
   output logic                   done,
   output logic                   error
);
   localparam int TW = $clog2(TIMEOUT + CLEAR_CYCLES) + 1;
   typedef enum logic [2:0] {IDLE, CLEAR, CLRWAIT, FILL, READ, RDWAIT, DONE, ERROR} state_t;
   state_t state_q, state_d;
   logic [COUNTBITS-1:0] num_q, num_d, count_q, count_d, count_inc;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [ADDRESSBITS-1:0] addr_q, addr_d;
   logic new_q, new_d, accept, tmo;
   assign count_inc = count_q + COUNTBITS'(count_q != '1);
   assign tmo = tmr_q == TW'(TIMEOUT - 1);
   assign accept = state_q == FILL && addrValid && storageReady;
   always_comb begin
      state_d = state_q;
      num_d = num_q;
      count_d = count_q;
      case (state_q)
         IDLE, ERROR: if (start) begin
            state_d = CLEAR;
            num_d = numWrites;
            count_d = '0;
         end
         CLEAR: state_d = tmr_q == TW'(CLEAR_CYCLES - 1) ? CLRWAIT : CLEAR;
         CLRWAIT: state_d = storageReady ? (num_q == '0 ? READ : FILL) : (tmo ? ERROR : CLRWAIT);
         FILL: if (accept) begin
            count_d = count_inc;
            state_d = count_inc == num_q ? READ : FILL;
         end else if (!storageReady && tmo) state_d = ERROR;
         READ: state_d = RDWAIT;
         RDWAIT: state_d = readReady ? DONE : (tmo ? ERROR : RDWAIT);
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort) begin
         state_d = IDLE;
         num_d = num_q;
         count_d = count_q;
      end
      // FILL only times out while storage is stalling, so readiness restarts the wait
      tmr_d = (state_d != state_q || (state_q == FILL && storageReady)) ? '0 : tmr_q + TW'(tmr_q != '1);
      new_d = accept && !abort;
      addr_d = new_d ? addrData : addr_q;
   end
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q <= IDLE;
         num_q <= '0;
         count_q <= '0;
         tmr_q <= '0;
         addr_q <= '0;
         new_q <= 1'b0;
      end else begin
         state_q <= state_d;
         num_q <= num_d;
         count_q <= count_d;
         tmr_q <= tmr_d;
         addr_q <= addr_d;
         new_q <= new_d;
      end
   end
   assign addrAccept = accept;
   assign clearMemory = state_q == CLEAR;
   assign readMemory = state_q == READ;
   assign done = state_q == DONE;
   assign error = state_q == ERROR;
   assign busy = !(state_q inside {IDLE, DONE, ERROR});
   assign newAddress = new_q;
   assign address = addr_q;
endmodule
